imem_loader: RTL and testbench

- Boot-time program loader that fills the instruction memory from a byte stream, e.g. a UART receiver.
- Accepts a word count and a start pulse, then collects bytes over a valid/ready handshake and assembles them little-endian into 32-bit words.
- Issues one word-aligned write per word on the instruction-memory write port, then checks a trailing XOR checksum byte.
- Sits between the serial receiver and the instruction-memory write side; the core's fetch path only reads.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the boot loader.
// The slave modport is the loader's view; master is the environment (receiver + memory).
interface imem_loader_if #(
  parameter int IMEM_W = 14,
  parameter int W      = 32
);
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic              wr_en_o;
  logic [IMEM_W-1:0] wr_addr_o;
  logic [W-1:0]      wr_data_o;

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    output rx_ready_o,
    output wr_en_o,
    output wr_addr_o,
    output wr_data_o
  );

  modport master (
    output rx_data_i,
    output rx_valid_i,
    input  rx_ready_o,
    input  wr_en_o,
    input  wr_addr_o,
    input  wr_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them to
// instruction memory and verifies a trailing XOR checksum byte.
//
// state   | meaning
// IDLE    | waiting for start_i; done/err from the previous load held
// RECV    | accepting the four bytes of the current word
// WRITE   | one-cycle write strobe for the assembled word
// CHECK   | accepting the checksum byte
// DONE    | one cycle with done set and busy cleared, then back to IDLE
module imem_loader #(
  parameter int IMEM_W = 14,
  parameter int W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [IMEM_W-3:0] len_i,
  imem_loader_if.slave      bus_io,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [IMEM_W-1:0] ADDR_STEP = IMEM_W'(4);
  localparam logic [IMEM_W-3:0] CNT_ONE   = (IMEM_W-2)'(1);

  state_t            state_q, state_d;
  logic [IMEM_W-3:0] cnt_q,   cnt_d;
  logic [1:0]        idx_q,   idx_d;
  logic [IMEM_W-1:0] addr_q,  addr_d;
  logic [W-1:0]      word_q,  word_d;
  logic [7:0]        csum_q,  csum_d;
  logic              rdy_q,   rdy_d;
  logic              wen_q,   wen_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  logic              accept;

  assign accept = bus_io.rx_valid_i & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    word_d  = word_q;
    csum_d  = csum_q;
    rdy_d   = rdy_q;
    wen_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b0;
        if (start_i) begin
          // A zero length wraps the down-counter, giving a full-depth load.
          cnt_d   = len_i;
          addr_d  = '0;
          idx_d   = 2'd0;
          csum_d  = 8'h00;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (accept) begin
          word_d[{idx_q, 3'b000} +: 8] = bus_io.rx_data_i;
          csum_d = csum_q ^ bus_io.rx_data_i;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            rdy_d   = 1'b0;
            wen_d   = 1'b1;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        addr_d = addr_q + ADDR_STEP;
        cnt_d  = cnt_q - CNT_ONE;
        rdy_d  = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_RECV;
        end
      end

      S_CHECK: begin
        if (accept) begin
          err_d   = (bus_io.rx_data_i != csum_q);
          rdy_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        rdy_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        rdy_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      word_q  <= '0;
      csum_q  <= 8'h00;
      rdy_q   <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      rdy_q   <= rdy_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.rx_ready_o = rdy_q;
  assign bus_io.wr_en_o    = wen_q;
  assign bus_io.wr_addr_o  = addr_q;
  assign bus_io.wr_data_o  = word_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random loads compared against a word/checksum
// model derived straight from the byte stream.
module tb_imem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-3:0] len_i = '0;
  logic          busy_o, done_o, err_o;

  imem_loader_if #(.IMEM_W(AW), .W(32)) bus ();

  imem_loader #(.IMEM_W(AW), .W(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start_i),
    .len_i  (len_i),
    .bus_io (bus),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected write sequence; monitor consumes it in order
  logic [AW-1:0] exp_addr [512];
  logic [31:0]   exp_data [512];
  int            exp_total = 0;

  int            errors = 0, checks = 0;
  int            merrors = 0, mchecks = 0;
  int            wr_seen = 0, done_rises = 0;
  logic          prev_done = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;

  logic [7:0]    stim [$];

  always @(negedge clk) begin
    if (!rst && bus.wr_en_o) begin
      mchecks <= mchecks + 1;
      if (wr_seen >= exp_total) begin
        merrors <= merrors + 1;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, no write expected",
                 bus.wr_addr_o, bus.wr_data_o);
      end else if (bus.wr_addr_o !== exp_addr[wr_seen] || bus.wr_data_o !== exp_data[wr_seen] ||
                   bus.rx_ready_o !== 1'b0) begin
        merrors <= merrors + 1;
        $display("FAIL write_%0d: got addr 0x%0h data 0x%08h ready %b, expected addr 0x%0h data 0x%08h ready 0",
                 wr_seen, bus.wr_addr_o, bus.wr_data_o, bus.rx_ready_o,
                 exp_addr[wr_seen], exp_data[wr_seen]);
      end
      last_addr <= bus.wr_addr_o;
      last_data <= bus.wr_data_o;
      wr_seen   <= wr_seen + 1;
    end
    if (done_o && !prev_done) done_rises <= done_rises + 1;
    prev_done <= done_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    logic r;
    ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      r = bus.rx_ready_o;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    chk("byte_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_load(input logic [1:0] len, input bit bad, input int gapmode, input bit midstart);
    int         nw, gap, t0, d0;
    logic [7:0] cs;
    bit         ok;
    nw = (len == 2'd0) ? 4 : int'(len);
    cs = 8'h00;
    for (int w = 0; w < nw; w++) begin
      exp_addr[exp_total + w] = AW'(w * 4);
      exp_data[exp_total + w] = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
    end
    for (int i = 0; i < 4 * nw; i++) cs = cs ^ stim[i];
    exp_total = exp_total + nw;

    @(negedge clk);
    start_i = 1'b1;
    len_i   = len;
    t0      = cyc;
    d0      = done_rises;
    @(negedge clk);
    start_i = 1'b0;
    len_i   = ~len;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    chk("done_cleared", {31'd0, done_o}, 32'd0);

    for (int i = 0; i < 4 * nw; i++) begin
      if (midstart && i == 5) begin
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        start_i = 1'b1;
        len_i   = 2'd1;
        @(negedge clk);
        start_i = 1'b0;
      end
      gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(stim[i], gap, ok);
      if (!ok) begin
        bus.rx_valid_i = 1'b0;
        return;
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, (gapmode == 1) ? 1 : 0, ok);
    if (!ok) begin
      bus.rx_valid_i = 1'b0;
      return;
    end

    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    bus.rx_valid_i = 1'b0;
    chk("load_finished", {31'd0, ok}, 32'd1);
    if (ok && gapmode == 0 && !midstart) chk("load_cycles", cyc - t0, 5 * nw + 3);
    chk("err", {31'd0, err_o}, {31'd0, bad});
    chk("busy_cleared", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("done_held", {31'd0, done_o}, 32'd1);
    chk("done_rises_once", done_rises - d0, 32'd1);
    chk("writes_seen", wr_seen, exp_total);
  endtask

  initial begin
    bit ok;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.rx_ready_o}, 32'd0);
    chk("rst_wen",   {31'd0, bus.wr_en_o},    32'd0);
    chk("rst_busy",  {31'd0, busy_o},         32'd0);
    chk("rst_done",  {31'd0, done_o},         32'd0);
    chk("rst_err",   {31'd0, err_o},          32'd0);
    rst = 1'b0;

    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2'd2, 1'b0, 0, 1'b0);
    chk("basic_last_data", last_data, 32'h00100093);
    chk("basic_last_addr", {28'd0, last_addr}, 32'h4);

    run_load(2'd2, 1'b1, 0, 1'b0);
    chk("badsum_err", {31'd0, err_o}, 32'd1);

    stim = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(2'd1, 1'b0, 1, 1'b0);
    chk("bp_last_data", last_data, 32'hDEADBEEF);
    chk("bp_last_addr", {28'd0, last_addr}, 32'h0);

    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    run_load(2'd0, 1'b0, 0, 1'b0);
    chk("full_last_data", last_data, 32'h0F0E0D0C);
    chk("full_last_addr", {28'd0, last_addr}, 32'hC);

    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom_range(0, 255)));
    run_load(2'd3, 1'b0, 0, 1'b1);

    // reset after two bytes of a word, then a fresh load must start at address 0
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 2'd2;
    @(negedge clk);
    start_i = 1'b0;
    send_byte(8'hAA, 0, ok);
    send_byte(8'h55, 0, ok);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.rx_ready_o}, 32'd0);
    chk("midrst_wen",   {31'd0, bus.wr_en_o},    32'd0);
    chk("midrst_busy",  {31'd0, busy_o},         32'd0);
    chk("midrst_done",  {31'd0, done_o},         32'd0);
    chk("midrst_err",   {31'd0, err_o},          32'd0);
    chk("midrst_addr",  {28'd0, bus.wr_addr_o},  32'd0);
    chk("midrst_data",  bus.wr_data_o,           32'd0);
    exp_total = wr_seen;
    @(negedge clk);
    rst = 1'b0;
    stim = '{8'h01, 8'h23, 8'h45, 8'h67};
    run_load(2'd1, 1'b0, 0, 1'b0);
    chk("postrst_addr", {28'd0, last_addr}, 32'h0);
    chk("postrst_data", last_data, 32'h67452301);

    for (int r = 0; r < 8; r++) begin
      logic [1:0] ln;
      int         nw;
      ln = 2'($urandom_range(0, 3));
      nw = (ln == 2'd0) ? 4 : int'(ln);
      stim.delete();
      for (int i = 0; i < 4 * nw; i++) stim.push_back(8'($urandom_range(0, 255)));
      run_load(ln, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (3) @(negedge clk);
    errors = errors + merrors;
    checks = checks + mchecks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
